// File: rtl/fetch_pkg.sv
// Fetch-stage constants, 2-bit counter encodings and helpers shared by the fetch bundle and its PHT.
// Pure definitions; no timing or flow-control behaviour of its own.
package fetch_pkg;

    localparam int FETCH_AW    = 8;
    localparam int FETCH_GHR_W = 5;

    localparam logic [5:0] OPC_BEQ = 6'h04;
    localparam logic [5:0] OPC_BNE = 6'h05;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    function automatic logic is_cond_branch(input logic [31:0] instr);
        return (instr[31:26] == OPC_BEQ) || (instr[31:26] == OPC_BNE);
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Gshare pattern history table: two combinational read ports, one synchronous saturating-update port.
// Reads see the pre-update value in the write cycle; updates are never held off.
module gshare_pht
    import fetch_pkg::*;
#(
    parameter int         IDX_W = FETCH_GHR_W,
    parameter logic [1:0] INIT  = CTR_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx0,
    input  logic [IDX_W-1:0] rd_idx1,
    output logic [1:0]       rd_ctr0,
    output logic [1:0]       rd_ctr1,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctr [DEPTH];

    assign rd_ctr0 = ctr[rd_idx0];
    assign rd_ctr1 = ctr[rd_idx1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= INIT;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_taken ? sat_inc(ctr[wr_idx]) : sat_dec(ctr[wr_idx]);
        end
    end

endmodule

// File: rtl/fetch_bundle_gen.sv
// Dual-issue fetch: PC/GHR owner, two-slot predecode and gshare prediction feeding the IF/ID register.
// Bundle is combinational from pc; redirect lands next cycle and beats stall; stall freezes PC/GHR only.
module fetch_bundle_gen
    import fetch_pkg::*;
#(
    parameter int         AW       = FETCH_AW,
    parameter int         GHR_W    = FETCH_GHR_W,
    parameter logic [1:0] PHT_INIT = CTR_WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [AW-1:0]    redirect_pc,
    input  logic [GHR_W-1:0] redirect_ghr,
    input  logic             upd_valid,
    input  logic [AW-1:0]    upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    output logic [AW-1:0]    imem_addr0,
    output logic [AW-1:0]    imem_addr1,
    input  logic [31:0]      imem_data0,
    input  logic [31:0]      imem_data1,
    output logic [31:0]      first_F,
    output logic [31:0]      second_F,
    output logic             first_branch_F,
    output logic             second_branch_F,
    output logic             first_prediction_F,
    output logic             second_prediction_F,
    output logic [AW-1:0]    first_next_addr_F,
    output logic [AW-1:0]    second_next_addr_F,
    output logic [AW-1:0]    first_target_addr_F,
    output logic [AW-1:0]    second_target_addr_F,
    output logic [GHR_W-1:0] ghr_F,
    output logic             second_flush
);

    logic [AW-1:0]    pc, pc_nxt;
    logic [GHR_W-1:0] ghr, ghr_nxt;

    logic [AW-1:0]    addr0, addr1, nxt0, nxt1, tgt0, tgt1;
    logic             br0, br1, pred0, pred1, take1;
    logic [1:0]       ctr0, ctr1;

    assign addr0 = pc;
    assign addr1 = pc + AW'(1);
    assign nxt0  = addr1;
    assign nxt1  = pc + AW'(2);

    assign br0 = is_cond_branch(imem_data0);
    assign br1 = is_cond_branch(imem_data1);

    // Size cast of a signed operand sign-extends the 8-bit displacement to AW.
    assign tgt0 = addr0 + AW'(1) + AW'($signed(imem_data0[7:0]));
    assign tgt1 = addr1 + AW'(1) + AW'($signed(imem_data1[7:0]));

    gshare_pht #(
        .IDX_W (GHR_W),
        .INIT  (PHT_INIT)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx0  (addr0[GHR_W-1:0] ^ ghr),
        .rd_idx1  (addr1[GHR_W-1:0] ^ ghr),
        .rd_ctr0  (ctr0),
        .rd_ctr1  (ctr1),
        .wr_en    (upd_valid),
        .wr_idx   (upd_pc[GHR_W-1:0] ^ upd_ghr),
        .wr_taken (upd_taken)
    );

    assign pred0 = br0 & ctr0[1];
    assign pred1 = br1 & ctr1[1];
    assign take1 = pred1 & ~pred0;

    always_comb begin
        pc_nxt  = nxt1;
        ghr_nxt = ghr;
        if (redirect) begin
            pc_nxt  = redirect_pc;
            ghr_nxt = redirect_ghr;
        end else if (stall) begin
            pc_nxt  = pc;
            ghr_nxt = ghr;
        end else if (pred0) begin
            pc_nxt  = tgt0;
            ghr_nxt = {ghr[GHR_W-2:0], 1'b1};
        end else if (take1) begin
            pc_nxt  = tgt1;
            ghr_nxt = br0 ? {ghr[GHR_W-3:0], 2'b01} : {ghr[GHR_W-2:0], 1'b1};
        end else begin
            // One not-taken history bit per branch in the bundle.
            if (br0) ghr_nxt = {ghr_nxt[GHR_W-2:0], 1'b0};
            if (br1) ghr_nxt = {ghr_nxt[GHR_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= '0;
            ghr <= '0;
        end else begin
            pc  <= pc_nxt;
            ghr <= ghr_nxt;
        end
    end

    assign imem_addr0 = addr0;
    assign imem_addr1 = addr1;

    assign first_F              = rst ? imem_data0 : '0;
    assign second_F             = rst ? imem_data1 : '0;
    assign first_branch_F       = rst & br0;
    assign second_branch_F      = rst & br1;
    assign first_prediction_F   = rst & pred0;
    assign second_prediction_F  = rst & pred1;
    assign first_next_addr_F    = rst ? nxt0 : '0;
    assign second_next_addr_F   = rst ? nxt1 : '0;
    assign first_target_addr_F  = rst ? tgt0 : '0;
    assign second_target_addr_F = rst ? tgt1 : '0;
    assign ghr_F                = rst ? ghr  : '0;
    assign second_flush         = rst & pred0;

endmodule

// File: tb/tb_fetch_bundle_gen.sv
// Directed bench for fetch_bundle_gen: predecode vector table plus hand sequences for
// training, saturation, redirect/stall, second-slot taken and asynchronous reset.
module tb_fetch_bundle_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, upd_valid, upd_taken;
    logic [7:0]  redirect_pc, upd_pc;
    logic [4:0]  redirect_ghr, upd_ghr;
    logic [7:0]  imem_addr0, imem_addr1;
    logic [31:0] imem_data0, imem_data1;
    logic [31:0] first_F, second_F;
    logic        first_branch_F, second_branch_F, first_prediction_F, second_prediction_F;
    logic [7:0]  first_next_addr_F, second_next_addr_F, first_target_addr_F, second_target_addr_F;
    logic [4:0]  ghr_F;
    logic        second_flush;

    logic [31:0] mem [256];
    assign imem_data0 = mem[imem_addr0];
    assign imem_data1 = mem[imem_addr1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_bundle_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .redirect             (redirect),
        .redirect_pc          (redirect_pc),
        .redirect_ghr         (redirect_ghr),
        .upd_valid            (upd_valid),
        .upd_pc               (upd_pc),
        .upd_ghr              (upd_ghr),
        .upd_taken            (upd_taken),
        .imem_addr0           (imem_addr0),
        .imem_addr1           (imem_addr1),
        .imem_data0           (imem_data0),
        .imem_data1           (imem_data1),
        .first_F              (first_F),
        .second_F             (second_F),
        .first_branch_F       (first_branch_F),
        .second_branch_F      (second_branch_F),
        .first_prediction_F   (first_prediction_F),
        .second_prediction_F  (second_prediction_F),
        .first_next_addr_F    (first_next_addr_F),
        .second_next_addr_F   (second_next_addr_F),
        .first_target_addr_F  (first_target_addr_F),
        .second_target_addr_F (second_target_addr_F),
        .ghr_F                (ghr_F),
        .second_flush         (second_flush)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [4:0]  ghr;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        br0;
        logic        br1;
        logic [7:0]  tgt0;
        logic [7:0]  tgt1;
        logic [7:0]  nxt0;
        logic [7:0]  nxt1;
        logic [7:0]  next_pc;
        logic [4:0]  next_ghr;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [7:0] p, input logic [4:0] g);
        redirect     = 1'b1;
        redirect_pc  = p;
        redirect_ghr = g;
        tick();
        redirect     = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a1;
        logic       exp_nt [5];

        // pc, ghr, slot0, slot1, br0, br1, tgt0, tgt1, nxt0, nxt1, next pc, next ghr
        vt[0] = '{8'h02, 5'h03, 32'h1000_0005, 32'h0000_0000, 1'b1, 1'b0, 8'h08, 8'h04, 8'h03, 8'h04, 8'h04, 5'h06};
        vt[1] = '{8'h10, 5'h01, 32'h0000_0000, 32'h1400_00FE, 1'b0, 1'b1, 8'h11, 8'h10, 8'h11, 8'h12, 8'h12, 5'h02};
        vt[2] = '{8'h20, 5'h05, 32'h1000_0080, 32'h1400_0010, 1'b1, 1'b1, 8'hA1, 8'h32, 8'h21, 8'h22, 8'h22, 5'h14};
        vt[3] = '{8'hFE, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 5'h00};
        vt[4] = '{8'hFF, 5'h1F, 32'h1800_0003, 32'h1000_0001, 1'b0, 1'b1, 8'h03, 8'h02, 8'h00, 8'h01, 8'h01, 5'h1E};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; redirect_ghr = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;

        // Reset state
        #12;
        check("rst_addr0", imem_addr0, 8'h00);
        check("rst_addr1", imem_addr1, 8'h01);
        check("rst_next1", second_next_addr_F, 8'h00);
        check("rst_ghr", ghr_F, 5'h00);
        tick();
        rst = 1'b1;
        #1;

        // Straight-line NOP fetch
        for (int k = 0; k < 3; k++) begin
            check($sformatf("nop_addr0_%0d", k), imem_addr0, 8'(2 * k));
            check($sformatf("nop_br_%0d", k), {first_branch_F, second_branch_F, first_prediction_F,
                                                second_prediction_F, second_flush}, 5'b0);
            check($sformatf("nop_ghr_%0d", k), ghr_F, 5'h00);
            if (k < 2) tick();
        end

        // Predecode table, PHT untrained so nothing predicts taken
        foreach (vt[i]) begin
            a1 = vt[i].pc + 8'd1;
            mem[vt[i].pc] = vt[i].i0;
            mem[a1]       = vt[i].i1;
            do_redirect(vt[i].pc, vt[i].ghr);
            check($sformatf("v%0d_first_F", i), first_F, vt[i].i0);
            check($sformatf("v%0d_addr1", i), imem_addr1, a1);
            check($sformatf("v%0d_br", i), {first_branch_F, second_branch_F}, {vt[i].br0, vt[i].br1});
            check($sformatf("v%0d_tgt0", i), first_target_addr_F, vt[i].tgt0);
            check($sformatf("v%0d_tgt1", i), second_target_addr_F, vt[i].tgt1);
            check($sformatf("v%0d_nxt", i), {first_next_addr_F, second_next_addr_F}, {vt[i].nxt0, vt[i].nxt1});
            check($sformatf("v%0d_pred", i), {first_prediction_F, second_prediction_F, second_flush}, 3'b000);
            check($sformatf("v%0d_ghr", i), ghr_F, vt[i].ghr);
            tick();
            check($sformatf("v%0d_next_pc", i), imem_addr0, vt[i].next_pc);
            check($sformatf("v%0d_next_ghr", i), ghr_F, vt[i].next_ghr);
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Train BEQ at pc=2, ghr=0 to taken
        mem[2] = 32'h1000_0005;
        do_redirect(8'h02, 5'h00);
        stall = 1'b1;
        check("beq_tgt", first_target_addr_F, 8'h08);
        check("beq_pred_init", first_prediction_F, 1'b0);
        upd_valid = 1'b1; upd_pc = 8'h02; upd_ghr = 5'h00; upd_taken = 1'b1;
        #1;
        check("beq_no_bypass", first_prediction_F, 1'b0);
        tick();
        tick();
        upd_valid = 1'b0;
        #1;
        check("beq_pred_trained", first_prediction_F, 1'b1);
        check("beq_flush", second_flush, 1'b1);
        stall = 1'b0;
        tick();
        check("beq_taken_pc", imem_addr0, 8'h08);
        check("beq_taken_ghr", ghr_F, 5'h01);

        // Saturation at index 0x10 (pc=0x10, ghr=0)
        mem[8'h10] = 32'h1000_0000;
        do_redirect(8'h10, 5'h00);
        stall = 1'b1;
        upd_valid = 1'b1; upd_pc = 8'h10; upd_ghr = 5'h00; upd_taken = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("sat_hi_pred", first_prediction_F, 1'b1);
        upd_taken = 1'b0;
        exp_nt = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat_nt_%0d", k), first_prediction_F, exp_nt[k]);
        end
        upd_taken = 1'b1;
        tick();
        check("sat_lo_t1", first_prediction_F, 1'b0);
        tick();
        check("sat_lo_t2", first_prediction_F, 1'b1);
        upd_valid = 1'b0;

        // Second slot predicted taken (slot1 at 0x10 uses the trained entry)
        mem[8'h0F] = 32'h0;
        mem[8'h10] = 32'h1000_0003;
        do_redirect(8'h0F, 5'h00);
        stall = 1'b0;
        check("s2_pred", {second_branch_F, second_prediction_F, first_prediction_F, second_flush}, 4'b1100);
        check("s2_tgt", second_target_addr_F, 8'h14);
        tick();
        check("s2_pc", imem_addr0, 8'h14);
        check("s2_ghr", ghr_F, 5'h01);

        // Redirect overrides stall, then stall holds
        stall = 1'b1;
        do_redirect(8'h40, 5'h1A);
        check("redir_pc", imem_addr0, 8'h40);
        check("redir_ghr", ghr_F, 5'h1A);
        tick();
        check("stall_pc", imem_addr0, 8'h40);
        check("stall_ghr", ghr_F, 5'h1A);
        stall = 1'b0;

        // Asynchronous reset mid-bundle
        mem[8'h40] = 32'h1000_0005;
        #2;
        rst = 1'b0;
        #1;
        check("arst_first_F", first_F, 32'h0);
        check("arst_br", {first_branch_F, first_prediction_F, second_flush}, 3'b000);
        check("arst_tgt", first_target_addr_F, 8'h00);
        check("arst_addr", {imem_addr0, imem_addr1}, 16'h0001);
        check("arst_ghr", ghr_F, 5'h00);
        tick();
        rst = 1'b1;
        #1;
        check("arst_rel_pc", imem_addr0, 8'h00);
        do_redirect(8'h02, 5'h00);
        check("arst_pht_br", first_branch_F, 1'b1);
        check("arst_pht_pred", first_prediction_F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
